daq_dma_framer: RTL

Single-clock stream framer sitting directly downstream of the DAQ DMA output, on the DMA clock. It consumes the 64-bit DMA word stream (valid/ready/last), wraps each event in a header word (magic, FPGA id, event number) and a trailer word (payload word count, 32-bit XOR checksum), and presents the framed stream to the host DMA engine with full backpressure. Its `in_ready` output drives the upstream `dma_ready`.

---
 rtl/daq_dma_framer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/daq_dma_framer.sv
// rtl/daq_dma_framer.sv - DAQ DMA stream framer
// Wraps each DMA event in a header (magic, fpga id, event number) and a trailer (word count, XOR checksum).
module daq_dma_framer #(
  parameter logic [7:0]  HDR_MAGIC = 8'hBE,
  parameter logic [7:0]  TRL_MAGIC = 8'hEF,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        dma_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [7:0]  fpga_id,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        m_valid,
  output logic [63:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [31:0] event_number,
  output logic [31:0] events_sent
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY, S_TRAILER} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   m_valid_q, m_valid_d;
  logic [63:0]            m_data_q, m_data_d;
  logic                   m_last_q, m_last_d;
  logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;
  logic [31:0]            csum_q, csum_d;
  logic [31:0]            event_number_q, event_number_d;
  logic [31:0]            events_sent_q, events_sent_d;
  logic [15:0]            cnt16;
  logic                   ld;
  logic                   xfer;

  assign ld       = !m_valid_q || m_ready;
  assign in_ready = (state_q == S_BODY) && ld;
  assign xfer     = in_valid && in_ready;

  generate
    if (CNT_WIDTH >= 16) begin : g_cnt_trunc
      assign cnt16 = word_count_q[15:0];
    end else begin : g_cnt_ext
      assign cnt16 = {{(16-CNT_WIDTH){1'b0}}, word_count_q};
    end
  endgenerate

  always_ff @(posedge dma_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      m_valid_q      <= 1'b0;
      m_data_q       <= 64'h0;
      m_last_q       <= 1'b0;
      word_count_q   <= '0;
      csum_q         <= 32'h0;
      event_number_q <= 32'h0;
      events_sent_q  <= 32'h0;
    end else begin
      state_q        <= state_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      word_count_q   <= word_count_d;
      csum_q         <= csum_d;
      event_number_q <= event_number_d;
      events_sent_q  <= events_sent_d;
    end
  end

  // The input word that opens an event is only looked at here, not consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enable && in_valid) state_d = S_HEADER;
      S_HEADER:  if (ld)                 state_d = S_BODY;
      S_BODY:    if (xfer && in_last)    state_d = S_TRAILER;
      S_TRAILER: if (ld)                 state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_last_d       = m_last_q;
    word_count_d   = word_count_q;
    csum_d         = csum_q;
    event_number_d = event_number_q;
    events_sent_d  = events_sent_q;

    if (ld) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      unique case (state_q)
        S_HEADER: begin
          m_valid_d    = 1'b1;
          m_data_d     = {HDR_MAGIC, fpga_id, 16'h0, event_number_q};
          word_count_d = '0;
          csum_d       = 32'h0;
        end
        S_BODY: begin
          if (xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            if (word_count_q != '1) word_count_d = word_count_q + CNT_ONE;
            csum_d    = csum_q ^ in_data[63:32] ^ in_data[31:0];
          end
        end
        S_TRAILER: begin
          m_valid_d      = 1'b1;
          m_data_d       = {TRL_MAGIC, 8'h0, cnt16, csum_q};
          m_last_d       = 1'b1;
          event_number_d = event_number_q + 32'd1;
        end
        default: ;
      endcase
    end

    if (m_valid_q && m_ready && m_last_q) events_sent_d = events_sent_q + 32'd1;

    // clear outranks any same-cycle increment of either counter
    if (clear) begin
      event_number_d = 32'h0;
      events_sent_d  = 32'h0;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign busy         = (state_q != S_IDLE);
  assign event_number = event_number_q;
  assign events_sent  = events_sent_q;

endmodule
